// File: rtl/bisynchronous_normal_queue.sv
// Valid/ready FIFO with wrap-bit pointers and no bypass path.
// Storage is flop-based so the asynchronous reset can clear every entry.
module bisynchronous_normal_queue #(
    parameter int p_num_bits         = 32,
    parameter int p_num_entries_bits = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  w_val,
    output logic                  w_rdy,
    input  logic [p_num_bits-1:0] w_msg,
    output logic                  r_val,
    input  logic                  r_rdy,
    output logic [p_num_bits-1:0] r_msg
);

    localparam int depth = 2 ** p_num_entries_bits;

    logic [p_num_entries_bits:0]   w_ptr_with_wrapbit_q, w_ptr_with_wrapbit_d;
    logic [p_num_entries_bits:0]   r_ptr_with_wrapbit_q, r_ptr_with_wrapbit_d;
    logic [p_num_bits-1:0]         mem_q [depth];
    logic [p_num_bits-1:0]         mem_d [depth];

    logic [p_num_entries_bits-1:0] w_idx;
    logic [p_num_entries_bits-1:0] r_idx;
    logic                          w_wrap;
    logic                          r_wrap;
    logic                          empty;
    logic                          full;
    logic                          w_fire;
    logic                          r_fire;

    assign w_idx  = w_ptr_with_wrapbit_q[p_num_entries_bits-1:0];
    assign r_idx  = r_ptr_with_wrapbit_q[p_num_entries_bits-1:0];
    assign w_wrap = w_ptr_with_wrapbit_q[p_num_entries_bits];
    assign r_wrap = r_ptr_with_wrapbit_q[p_num_entries_bits];

    // Flags depend only on the pointers, never on w_val or r_rdy.
    assign empty  = (w_ptr_with_wrapbit_q == r_ptr_with_wrapbit_q);
    assign full   = (w_idx == r_idx) && (w_wrap != r_wrap);
    assign w_rdy  = !full;
    assign r_val  = !empty;
    assign r_msg  = mem_q[r_idx];

    assign w_fire = w_val && w_rdy;
    assign r_fire = r_val && r_rdy;

    always_comb begin
        w_ptr_with_wrapbit_d = w_ptr_with_wrapbit_q;
        r_ptr_with_wrapbit_d = r_ptr_with_wrapbit_q;
        if (w_fire) begin
            w_ptr_with_wrapbit_d = w_ptr_with_wrapbit_q + 1'b1;
        end
        if (r_fire) begin
            r_ptr_with_wrapbit_d = r_ptr_with_wrapbit_q + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < depth; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (w_fire) begin
            mem_d[w_idx] = w_msg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_ptr_with_wrapbit_q <= '0;
            r_ptr_with_wrapbit_q <= '0;
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            w_ptr_with_wrapbit_q <= w_ptr_with_wrapbit_d;
            r_ptr_with_wrapbit_q <= r_ptr_with_wrapbit_d;
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_bisynchronous_normal_queue.sv
// Directed bench for bisynchronous_normal_queue: reset, burst, drain, no-bypass,
// fill/wrap and full-with-simultaneous-access cases with hand-computed values.
module tb_bisynchronous_normal_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        w_val;
    logic        w_rdy;
    logic [31:0] w_msg;
    logic        r_val;
    logic        r_rdy;
    logic [31:0] r_msg;

    int checks   = 0;
    int failures = 0;

    bisynchronous_normal_queue #(
        .p_num_bits         (32),
        .p_num_entries_bits (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .w_val (w_val),
        .w_rdy (w_rdy),
        .w_msg (w_msg),
        .r_val (r_val),
        .r_rdy (r_rdy),
        .r_msg (r_msg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one edge, then settle 1 time unit past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        w_val = 1'b0;
        r_rdy = 1'b0;
        w_msg = '0;

        // Reset asserted mid-cycle, away from the clock edge
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("rst_w_rdy", 32'(w_rdy), 1);
        check("rst_r_val", 32'(r_val), 0);
        check("rst_r_msg", r_msg, 0);
        check("rst_w_ptr", 32'(dut.w_ptr_with_wrapbit_q), 0);
        check("rst_r_ptr", 32'(dut.r_ptr_with_wrapbit_q), 0);
        check("rst_mem0", dut.mem_q[0], 0);
        check("rst_mem1", dut.mem_q[1], 0);
        check("rst_mem2", dut.mem_q[2], 0);
        step();
        reset = 1'b1;
        $display("reset done");

        // Burst write 5, f, a
        w_val = 1'b1; w_msg = 32'h5;
        step();
        check("burst_r_val", 32'(r_val), 1);
        check("burst_r_msg", r_msg, 32'h5);
        check("burst_mem0", dut.mem_q[0], 32'h5);
        w_msg = 32'hf;
        step();
        check("burst_mem1", dut.mem_q[1], 32'hf);
        w_msg = 32'ha;
        step();
        w_val = 1'b0;
        check("burst_w_ptr", 32'(dut.w_ptr_with_wrapbit_q), 3);
        check("burst_mem2", dut.mem_q[2], 32'ha);
        for (int i = 0; i < 50; i++) step();
        check("idle_r_val", 32'(r_val), 1);
        check("idle_r_msg", r_msg, 32'h5);
        check("idle_w_ptr", 32'(dut.w_ptr_with_wrapbit_q), 3);
        $display("burst write 5,f,a done");

        // Drain
        r_rdy = 1'b1;
        #1;
        check("drain0_r_msg", r_msg, 32'h5);
        step();
        check("drain1_r_msg", r_msg, 32'hf);
        step();
        check("drain2_r_msg", r_msg, 32'ha);
        step();
        check("drain_r_val", 32'(r_val), 0);
        check("drain_r_ptr", 32'(dut.r_ptr_with_wrapbit_q), 3);
        for (int i = 0; i < 50; i++) step();
        check("empty_hold_r_ptr", 32'(dut.r_ptr_with_wrapbit_q), 3);
        check("empty_hold_r_val", 32'(r_val), 0);
        $display("drain done");

        // Write into empty queue with reader ready: no bypass
        w_val = 1'b1; w_msg = 32'h3;
        #1;
        check("nobyp_pre_r_val", 32'(r_val), 0);
        step();
        check("nobyp_r_val", 32'(r_val), 1);
        check("nobyp_r_msg", r_msg, 32'h3);
        check("nobyp_r_ptr", 32'(dut.r_ptr_with_wrapbit_q), 3);
        w_val = 1'b0;
        step();
        check("nobyp_deq_r_val", 32'(r_val), 0);
        check("nobyp_deq_r_ptr", 32'(dut.r_ptr_with_wrapbit_q), 4);
        check("nobyp_w_ptr", 32'(dut.w_ptr_with_wrapbit_q), 4);
        $display("write-then-read from empty done");

        // Fill 4 entries starting at pointer 100
        r_rdy = 1'b0; w_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_msg = 32'h10 + 32'(i);
            step();
        end
        check("fill_w_rdy", 32'(w_rdy), 0);
        check("fill_w_ptr", 32'(dut.w_ptr_with_wrapbit_q), 0);
        check("fill_r_ptr", 32'(dut.r_ptr_with_wrapbit_q), 4);
        w_msg = 32'h99;
        step();
        check("fifth_w_ptr", 32'(dut.w_ptr_with_wrapbit_q), 0);
        check("fifth_w_rdy", 32'(w_rdy), 0);
        check("fifth_mem0", dut.mem_q[0], 32'h10);
        check("fifth_r_msg", r_msg, 32'h10);

        // One read frees a slot; next write recycles it with wrap toggled
        w_val = 1'b0; r_rdy = 1'b1;
        step();
        r_rdy = 1'b0;
        check("free_w_rdy", 32'(w_rdy), 1);
        check("free_r_msg", r_msg, 32'h11);
        check("free_r_ptr", 32'(dut.r_ptr_with_wrapbit_q), 5);
        w_val = 1'b1; w_msg = 32'h14;
        step();
        w_val = 1'b0;
        check("recycle_w_ptr", 32'(dut.w_ptr_with_wrapbit_q), 1);
        check("recycle_mem0", dut.mem_q[0], 32'h14);
        check("recycle_w_rdy", 32'(w_rdy), 0);
        $display("fill and wrap done");

        // Full with simultaneous read and write: only the read happens
        w_val = 1'b1; w_msg = 32'h55; r_rdy = 1'b1;
        #1;
        check("fullrw_pre_w_rdy", 32'(w_rdy), 0);
        step();
        check("fullrw_w_ptr", 32'(dut.w_ptr_with_wrapbit_q), 1);
        check("fullrw_r_ptr", 32'(dut.r_ptr_with_wrapbit_q), 6);
        check("fullrw_r_msg", r_msg, 32'h12);
        check("fullrw_w_rdy", 32'(w_rdy), 1);
        step();
        w_val = 1'b0;
        check("both_w_ptr", 32'(dut.w_ptr_with_wrapbit_q), 2);
        check("both_r_ptr", 32'(dut.r_ptr_with_wrapbit_q), 7);
        check("both_mem1", dut.mem_q[1], 32'h55);
        check("both_r_msg", r_msg, 32'h13);
        check("both_w_rdy", 32'(w_rdy), 1);
        check("both_r_val", 32'(r_val), 1);
        step();
        check("order0_r_msg", r_msg, 32'h14);
        step();
        check("order1_r_msg", r_msg, 32'h55);
        step();
        check("order_end_r_val", 32'(r_val), 0);
        r_rdy = 1'b0;
        $display("full with simultaneous read/write done");

        // Reset in the middle of traffic discards contents
        w_val = 1'b1; w_msg = 32'h77;
        step();
        check("pre_rst_r_val", 32'(r_val), 1);
        #2 reset = 1'b0;
        #1;
        check("midrst_r_val", 32'(r_val), 0);
        check("midrst_w_rdy", 32'(w_rdy), 1);
        check("midrst_r_msg", r_msg, 0);
        w_val = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("post_rst_r_val", 32'(r_val), 0);
        $display("mid-operation reset done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the bench always terminates
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bisynchronous_normal_queue.md
Name: bisynchronous_normal_queue

Overview:
Registered-output-free FIFO with valid/ready handshakes on both the write (enqueue) and read (dequeue) sides. This single-clock build keeps the bisynchronous queue interface, so producers and consumers port over unchanged. It is a "normal" queue: no bypass or pipe path, so a written entry is visible to the reader one clock edge after it is accepted. It sits between a producer and a consumer as a generic buffering element.

Parameters:
- p_num_bits, 32, data width of each entry in bits.
- p_num_entries_bits, 2, log2 of the queue depth; the depth is 2**p_num_entries_bits (default 4 entries).

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- w_val  input  1  producer has a valid message on w_msg.
- w_rdy  output  1  queue can accept a message (not full).
- w_msg  input  p_num_bits  message to enqueue.
- r_val  output  1  queue holds at least one message (not empty).
- r_rdy  input  1  consumer accepts r_msg this cycle.
- r_msg  output  p_num_bits  head-of-queue message.

Behaviour:
Storage and pointers:
- Storage is mem[0 .. 2**p_num_entries_bits - 1], each entry p_num_bits wide.
- w_ptr_with_wrapbit and r_ptr_with_wrapbit are each p_num_entries_bits+1 bits wide.
- The low bits of each pointer index mem; the MSB is the wrap bit.

Reset:
- Asserting reset low forces both pointers to 0 and clears every mem entry to 0 immediately, without waiting for clk.
- While in reset: w_rdy=1, r_val=0, r_msg=0.
- Reset taken in the middle of an operation discards all contents. Any in-flight handshake in that cycle is lost.

Status flags (combinational from the pointers):
- empty: both pointers are exactly equal.
- full: the index bits are equal and the wrap bits differ.
- w_rdy = !full.
- r_val = !empty.
- r_msg = mem[r_ptr index], combinational; its value is don't-care when r_val=0.

Write:
- On a rising edge with w_val && w_rdy: mem[w_ptr index] <= w_msg and w_ptr increments by 1 (mod 2**(p_num_entries_bits+1)).
- The index wraps from depth-1 to 0 and the wrap bit toggles.

Read:
- On a rising edge with r_val && r_rdy: r_ptr increments by 1 with the same wrap rule.
- mem is not modified by a read.

Latency and flow:
- A write accepted at edge N makes r_val=1 and r_msg valid after edge N.
- The earliest dequeue of that entry is at edge N+1.
- There is no same-cycle bypass: with the queue empty and w_val=1, r_rdy=1, nothing is dequeued at the first edge.

Boundary conditions:
- Full: w_val is ignored and there is no write or pointer change. Simultaneous read and write when full is still blocked on the write side, because w_rdy=0 in that cycle.
- Empty: r_rdy is ignored and r_ptr holds.
- Non-empty and non-full with simultaneous read and write: both occur in the same edge and the occupancy is unchanged.
- Valid and ready are independent. Neither w_rdy nor r_val depends combinationally on w_val or r_rdy.

Test Plan:
- Reset: drive reset low mid-cycle, then release -> both pointers 000, w_rdy=1, r_val=0, mem[0..2]=0.
- Burst write: w_val=1 with 5, 0xf, 0xa on three consecutive edges, then w_val=0 ->
  - after the first edge: r_val=1, r_msg=5, mem[0]=5;
  - after the second edge: mem[1]=0xf;
  - w_ptr ends at 011;
  - r_val stays 1 and r_msg stays 5 through 50 idle cycles.
- Drain: r_rdy=1 ->
  - r_msg=5 before the first read edge, 0xf before the second, 0xa before the third;
  - after three edges r_val=0 and r_ptr=011;
  - holding r_rdy=1 for 50 more cycles keeps r_ptr at 011.
- Write then read from empty: w_val=1 with w_msg=3 while r_rdy=1 ->
  - one edge later r_val=1 and r_msg=3 (no bypass);
  - drop w_val; next edge dequeues the entry and r_val=0.
- Fill and wrap:
  - write 4 entries with r_rdy=0 -> w_rdy=0, w_ptr=100+start;
  - a 5th w_val is ignored;
  - one read -> w_rdy=1;
  - the next write lands in the recycled slot with wrap bit toggled;
  - read order matches write order.
- Full with simultaneous read and write: with the queue full, assert w_val=1 and r_rdy=1 -> only the read occurs; next cycle both proceed and occupancy stays at 3.
